// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge
//
// Bridges single APB transfers onto a simple request/acknowledge register
// port. Each APB setup phase is decoded against a window of NUM_REGS word
// registers starting at BASE_ADDR. Illegal accesses and strobe-less writes
// are answered locally. Everything else is forwarded as reg_req and held
// until reg_ack arrives or the wait exceeds TIMEOUT cycles.
//
// Ports
//   pclk, preset          clock, synchronous active-high reset
//   psel, penable, pwrite APB control
//   paddr, pwdata, pstrb  APB byte address, write data, write strobes
//   pready, pslverr       registered APB response (one-cycle pulse)
//   prdata                registered read data, zero outside the response
//   reg_req, reg_we       register-side request and write flag
//   reg_idx               word index of the addressed register
//   reg_wdata, reg_strb   write data / strobes, stable while reg_req is high
//   reg_ack, reg_rdata    register-side completion and read data
//   err_cnt               saturating count of error responses

module apb_reg_bridge #(
    parameter int                  ADDR_W    = 13,
    parameter int                  DATA_W    = 32,
    parameter int                  NUM_REGS  = 5,
    parameter int                  BASE_ADDR = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter int                  TIMEOUT   = 15,
    localparam int                 SB        = DATA_W / 8,
    localparam int                 IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [SB-1:0]     pstrb,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] prdata,
    output logic              reg_req,
    output logic              reg_we,
    output logic [IDX_W-1:0]  reg_idx,
    output logic [DATA_W-1:0] reg_wdata,
    output logic [SB-1:0]     reg_strb,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [7:0]        err_cnt
);

    localparam int                ALIGN_BITS = $clog2(SB);
    localparam logic [ADDR_W:0]   BASE_VEC   = (ADDR_W + 1)'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(SB - 1);
    localparam logic [7:0]        TMO_LIMIT  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RESP
    } state_t;

    state_t            state;
    logic [7:0]        tmo_cnt;
    logic [7:0]        tmo_next;
    logic              aborted;
    logic              abort_seen;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] index;
    logic              misaligned;
    logic              below_base;
    logic              out_of_range;
    logic              ro_hit;
    logic              dec_err;

    // Address decode of the live APB inputs; only consumed in the setup
    // cycle. The byte mask is zero for 8-bit data, so alignment then
    // never fails.
    always_comb begin
        offset       = paddr - BASE_VEC[ADDR_W-1:0];
        index        = offset >> ALIGN_BITS;
        misaligned   = (paddr & ALIGN_MASK) != '0;
        below_base   = {1'b0, paddr} < BASE_VEC;
        out_of_range = index >= ADDR_W'(NUM_REGS);
        ro_hit       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i] && (index == ADDR_W'(i))) begin
                ro_hit = 1'b1;
            end
        end
        dec_err = misaligned | below_base | out_of_range
                | (pwrite & ro_hit) | (!pwrite && (pstrb != '0));
    end

    // Once the master has dropped psel during the wait, the response is
    // swallowed but the register handshake still runs to completion.
    assign abort_seen = aborted | ~psel;
    assign tmo_next   = tmo_cnt + 8'd1;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_idx   <= '0;
            reg_wdata <= '0;
            reg_strb  <= '0;
            err_cnt   <= '0;
            tmo_cnt   <= '0;
            aborted   <= 1'b0;
        end else begin
            // APB response outputs are pulses that only live in RESP.
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        aborted <= 1'b0;
                        tmo_cnt <= '0;
                        if (dec_err) begin
                            state   <= RESP;
                            pready  <= 1'b1;
                            pslverr <= 1'b1;
                        end else if (pwrite && (pstrb == '0)) begin
                            state  <= RESP;
                            pready <= 1'b1;
                        end else begin
                            state     <= WAIT_ACK;
                            reg_req   <= 1'b1;
                            reg_we    <= pwrite;
                            reg_idx   <= index[IDX_W-1:0];
                            reg_wdata <= pwdata;
                            reg_strb  <= pstrb;
                        end
                    end
                end

                WAIT_ACK: begin
                    aborted <= abort_seen;
                    tmo_cnt <= tmo_next;
                    // An acknowledge in the last allowed cycle beats the timeout.
                    if (reg_ack) begin
                        reg_req <= 1'b0;
                        state   <= abort_seen ? IDLE : RESP;
                        pready  <= !abort_seen;
                        if (!reg_we && !abort_seen) begin
                            prdata <= reg_rdata;
                        end
                    end else if (tmo_next == TMO_LIMIT) begin
                        reg_req <= 1'b0;
                        state   <= abort_seen ? IDLE : RESP;
                        pready  <= !abort_seen;
                        pslverr <= !abort_seen;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    if (pslverr && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// tb_apb_reg_bridge
//
// Drives APB transfers and a register-side responder, and keeps a
// transaction-level model of what the bridge must answer. The model derives
// the expected response for each transfer from its address, direction,
// strobes and acknowledge delay. A negedge process checks every output
// against the model each cycle. Directed transfers also pin latency and
// data to hand-computed literals.

`timescale 1ns/1ps

module tb_apb_reg_bridge;

    localparam int         NUM_REGS = 5;
    localparam int         TMO      = 15;
    localparam logic [4:0] RO       = 5'b00001;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [12:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic        reg_req;
    logic        reg_we;
    logic [2:0]  reg_idx;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_strb;
    logic        reg_ack;
    logic [31:0] reg_rdata;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state: expected outputs for the current cycle.
    logic        exp_pready;
    logic        exp_pslverr;
    logic [31:0] exp_prdata;
    logic        exp_req;
    logic        exp_we;
    logic [2:0]  exp_idx;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    int          err_model;

    // Observations of the most recent transfer, for literal checks.
    int          obs_lat;
    int          obs_req_cycles;
    logic        obs_pslverr;
    logic [31:0] obs_prdata;
    logic [2:0]  obs_idx;
    logic [3:0]  obs_strb;

    apb_reg_bridge #(
        .ADDR_W   (13),
        .DATA_W   (32),
        .NUM_REGS (NUM_REGS),
        .BASE_ADDR(0),
        .RO_MASK  (RO),
        .TIMEOUT  (TMO)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pready   (pready),
        .pslverr  (pslverr),
        .prdata   (prdata),
        .reg_req  (reg_req),
        .reg_we   (reg_we),
        .reg_idx  (reg_idx),
        .reg_wdata(reg_wdata),
        .reg_strb (reg_strb),
        .reg_ack  (reg_ack),
        .reg_rdata(reg_rdata),
        .err_cnt  (err_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge pclk) begin
        if (check_en) begin
            checkOutput("pready",  32'(pready),  32'(exp_pready));
            checkOutput("pslverr", 32'(pslverr), 32'(exp_pslverr));
            checkOutput("prdata",  prdata,       exp_prdata);
            checkOutput("reg_req", 32'(reg_req), 32'(exp_req));
            checkOutput("err_cnt", 32'(err_cnt), 32'(err_model));
            if (exp_req) begin
                checkOutput("reg_we",    32'(reg_we),   32'(exp_we));
                checkOutput("reg_idx",   32'(reg_idx),  32'(exp_idx));
                checkOutput("reg_wdata", reg_wdata,     exp_wdata);
                checkOutput("reg_strb",  32'(reg_strb), 32'(exp_strb));
            end
        end
    end

    // 0: forwarded to the register block, 1: decode error, 2: strobe-less write.
    function automatic int classify(input bit wr, input int addr, input logic [3:0] st);
        int idx;
        idx = addr / 4;
        if ((addr % 4) != 0) return 1;
        if (idx >= NUM_REGS) return 1;
        if (wr && RO[idx]) return 1;
        if (!wr && (st != 4'h0)) return 1;
        if (wr && (st == 4'h0)) return 2;
        return 0;
    endfunction

    task automatic setExpIdle();
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = 32'h0;
        exp_req     = 1'b0;
    endtask

    // Idle bus cycles with stray acknowledges that must be ignored.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            psel      = 1'b0;
            penable   = 1'b0;
            paddr     = 13'($urandom());
            pwrite    = 1'($urandom_range(0, 1));
            reg_ack   = 1'($urandom_range(0, 1));
            reg_rdata = $urandom();
            setExpIdle();
            @(posedge pclk); #1;
        end
    endtask

    // One APB transfer. ack_d: WAIT_ACK cycles before reg_ack (0 = first
    // cycle, negative = never). abort_k: cycle after setup at which psel
    // drops (0 = no abort). Entered and left just after a rising edge.
    task automatic applyStimulus(input bit wr, input logic [12:0] addr, input logic [31:0] wd,
                                 input logic [3:0] st, input int ack_d, input int abort_k,
                                 input logic [31:0] rd);
        int status;
        int wait_len;
        int resp_k;
        int end_k;
        bit timeout;
        bit aborted;
        bit in_wait;
        bit ack_now;
        status   = classify(wr, int'(addr), st);
        timeout  = 1'b0;
        wait_len = 0;
        if (status == 0) begin
            timeout  = (ack_d < 0) || (ack_d >= TMO);
            wait_len = timeout ? TMO : ack_d + 1;
        end
        resp_k  = wait_len + 1;
        aborted = (abort_k >= 1) && (abort_k <= wait_len);
        end_k   = aborted ? wait_len : resp_k;

        obs_lat        = -1;
        obs_req_cycles = 0;
        obs_pslverr    = 1'b0;
        obs_prdata     = 32'h0;
        obs_idx        = 3'h0;
        obs_strb       = 4'h0;
        paddr  = addr;
        pwrite = wr;
        pwdata = wd;
        pstrb  = st;

        for (int k = 0; k <= end_k; k++) begin
            psel    = !(aborted && (k >= abort_k));
            penable = psel && (k >= 1);
            in_wait = (k >= 1) && (k <= wait_len);
            ack_now = in_wait && !timeout && (k == wait_len);
            if (ack_now) begin
                reg_ack   = 1'b1;
                reg_rdata = rd;
            end else if (in_wait) begin
                reg_ack   = 1'b0;
                reg_rdata = $urandom();
            end else begin
                reg_ack   = 1'($urandom_range(0, 1));
                reg_rdata = $urandom();
            end
            exp_req     = in_wait;
            exp_we      = wr;
            exp_idx     = addr[4:2];
            exp_wdata   = wd;
            exp_strb    = st;
            exp_pready  = !aborted && (k == resp_k);
            exp_pslverr = exp_pready && ((status == 1) || timeout);
            exp_prdata  = (exp_pready && (status == 0) && !timeout && !wr) ? rd : 32'h0;
            @(negedge pclk);
            if (reg_req === 1'b1) begin
                obs_req_cycles++;
                obs_idx  = reg_idx;
                obs_strb = reg_strb;
            end
            if ((pready === 1'b1) && (obs_lat < 0)) begin
                obs_lat     = k;
                obs_pslverr = pslverr;
                obs_prdata  = prdata;
            end
            @(posedge pclk); #1;
            if (exp_pslverr && (err_model < 255)) err_model++;
        end
        psel    = 1'b0;
        penable = 1'b0;
        reg_ack = 1'b0;
        setExpIdle();
    endtask

    initial begin
        bit          wr;
        int          sel;
        int          r;
        int          ack_d;
        int          abort_k;
        logic [12:0] a;
        logic [3:0]  st;

        preset    = 1'b1;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        pstrb     = '0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        err_model = 0;
        exp_we    = 1'b0;
        exp_idx   = '0;
        exp_wdata = '0;
        exp_strb  = '0;
        setExpIdle();
        repeat (2) @(posedge pclk);
        #1;
        preset   = 1'b0;
        check_en = 1'b1;
        @(negedge pclk);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("reset_reg_req", 32'(reg_req), 32'd0);
        checkOutput("reset_pready",  32'(pready),  32'd0);
        @(posedge pclk); #1;

        // Write to register 1, acknowledged in the first wait cycle.
        applyStimulus(1'b1, 13'h004, 32'hA5A5A5A5, 4'hF, 0, 0, 32'h0);
        checkOutput("wr004_latency",  32'(obs_lat),        32'd2);
        checkOutput("wr004_req_cyc",  32'(obs_req_cycles), 32'd1);
        checkOutput("wr004_idx",      32'(obs_idx),        32'd1);
        checkOutput("wr004_strb",     32'(obs_strb),       32'hF);
        checkOutput("wr004_pslverr",  32'(obs_pslverr),    32'd0);

        // Read with an acknowledge three cycles late.
        applyStimulus(1'b0, 13'h008, 32'h0, 4'h0, 3, 0, 32'h12345678);
        checkOutput("rd008_latency", 32'(obs_lat),     32'd5);
        checkOutput("rd008_prdata",  obs_prdata,       32'h12345678);
        checkOutput("rd008_pslverr", 32'(obs_pslverr), 32'd0);

        // Out-of-range index and misaligned address.
        applyStimulus(1'b0, 13'h014, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF);
        checkOutput("rd014_latency", 32'(obs_lat),        32'd1);
        checkOutput("rd014_pslverr", 32'(obs_pslverr),    32'd1);
        checkOutput("rd014_prdata",  obs_prdata,          32'h0);
        checkOutput("rd014_req_cyc", 32'(obs_req_cycles), 32'd0);
        applyStimulus(1'b0, 13'h002, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF);
        checkOutput("rd002_latency", 32'(obs_lat),        32'd1);
        checkOutput("rd002_pslverr", 32'(obs_pslverr),    32'd1);
        checkOutput("rd002_req_cyc", 32'(obs_req_cycles), 32'd0);
        @(negedge pclk);
        checkOutput("two_errors_err_cnt", 32'(err_cnt), 32'd2);
        @(posedge pclk); #1;

        // Read-only register write and strobe-less write.
        applyStimulus(1'b1, 13'h000, 32'h11112222, 4'hF, 0, 0, 32'h0);
        checkOutput("wr000_ro_pslverr", 32'(obs_pslverr), 32'd1);
        applyStimulus(1'b1, 13'h00C, 32'h33334444, 4'h0, 0, 0, 32'h0);
        checkOutput("wr00c_nostrb_pslverr", 32'(obs_pslverr),    32'd0);
        checkOutput("wr00c_nostrb_req_cyc", 32'(obs_req_cycles), 32'd0);
        checkOutput("wr00c_nostrb_latency", 32'(obs_lat),        32'd1);

        // Acknowledge in the last allowed cycle, then one cycle too late.
        applyStimulus(1'b0, 13'h010, 32'h0, 4'h0, 14, 0, 32'h0BADCAFE);
        checkOutput("ack_last_latency", 32'(obs_lat),     32'd16);
        checkOutput("ack_last_pslverr", 32'(obs_pslverr), 32'd0);
        checkOutput("ack_last_prdata",  obs_prdata,       32'h0BADCAFE);
        applyStimulus(1'b0, 13'h010, 32'h0, 4'h0, 15, 0, 32'h0BADCAFE);
        checkOutput("ack_late_latency", 32'(obs_lat),        32'd16);
        checkOutput("ack_late_pslverr", 32'(obs_pslverr),    32'd1);
        checkOutput("ack_late_req_cyc", 32'(obs_req_cycles), 32'd15);

        // psel dropped mid-wait: handshake completes, no response.
        applyStimulus(1'b0, 13'h008, 32'h0, 4'h0, 2, 1, 32'h55AA55AA);
        checkOutput("abort_latency", 32'(obs_lat),        32'hFFFFFFFF);
        checkOutput("abort_req_cyc", 32'(obs_req_cycles), 32'd3);

        // Reset in the middle of a wait for acknowledge.
        paddr  = 13'h00C;
        pwrite = 1'b0;
        pstrb  = 4'h0;
        pwdata = $urandom();
        for (int k = 0; k <= 3; k++) begin
            psel        = 1'b1;
            penable     = (k >= 1);
            reg_ack     = 1'b0;
            reg_rdata   = $urandom();
            preset      = (k == 3);
            exp_req     = (k >= 1);
            exp_we      = 1'b0;
            exp_idx     = 3'd3;
            exp_wdata   = pwdata;
            exp_strb    = 4'h0;
            exp_pready  = 1'b0;
            exp_pslverr = 1'b0;
            exp_prdata  = 32'h0;
            @(posedge pclk); #1;
        end
        preset    = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        err_model = 0;
        setExpIdle();
        @(negedge pclk);
        checkOutput("midreset_reg_req", 32'(reg_req), 32'd0);
        checkOutput("midreset_pready",  32'(pready),  32'd0);
        checkOutput("midreset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge pclk); #1;
        applyStimulus(1'b0, 13'h000, 32'h0, 4'h0, 1, 0, 32'hCAFEF00D);
        checkOutput("post_reset_latency", 32'(obs_lat),     32'd3);
        checkOutput("post_reset_prdata",  obs_prdata,       32'hCAFEF00D);
        checkOutput("post_reset_pslverr", 32'(obs_pslverr), 32'd0);

        // Randomized traffic against the model.
        for (int t = 0; t < 200; t++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 6)      a = 13'($urandom_range(0, 6) * 4);
            else if (sel < 8) a = 13'($urandom_range(0, 31));
            else              a = 13'($urandom_range(0, 8191));
            r = $urandom_range(0, 9);
            if (wr) st = (r < 7) ? 4'hF : ((r == 7) ? 4'h0 : 4'($urandom()));
            else    st = (r < 8) ? 4'h0 : 4'($urandom());
            r = $urandom_range(0, 9);
            if (r < 7)       ack_d = $urandom_range(0, 4);
            else if (r == 7) ack_d = $urandom_range(5, 16);
            else             ack_d = -1;
            abort_k = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0;
            applyStimulus(wr, a, $urandom(), st, ack_d, abort_k, $urandom());
            idleCycles($urandom_range(0, 2));
        end

        // Timeouts until the error counter saturates.
        for (int t = 0; t < 256; t++) begin
            applyStimulus(1'b0, 13'h00C, 32'h0, 4'h0, -1, 0, 32'h0);
        end
        checkOutput("timeout_latency", 32'(obs_lat),        32'd16);
        checkOutput("timeout_pslverr", 32'(obs_pslverr),    32'd1);
        checkOutput("timeout_req_cyc", 32'(obs_req_cycles), 32'd15);
        @(negedge pclk);
        checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);
        @(posedge pclk); #1;

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish before 1000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_reg_bridge.md
APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 Parameter ADDR_W, default 13, APB address width.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be 8, 16 or 32; SB = DATA_W/8 bytes.
REQ-003 Parameter NUM_REGS, default 5, number of word registers behind the bridge.
REQ-004 Parameter BASE_ADDR, default 0, byte address of register 0.
REQ-005 Parameter RO_MASK, default 0, NUM_REGS bits; bit i=1 marks register i read-only.
REQ-006 Parameter TIMEOUT, default 15, maximum cycles to wait for reg_ack (1..255).
REQ-007 pclk  in  1  sole clock, all logic on rising edge.
REQ-008 preset  in  1  synchronous, active-high reset.
REQ-009 psel, penable, pwrite  in  1 each  APB controls.
REQ-010 paddr  in  ADDR_W  byte address.
REQ-011 pwdata  in  DATA_W  write data.
REQ-012 pstrb  in  SB  write byte strobes.
REQ-013 pready, pslverr  out  1 each  registered APB response.
REQ-014 prdata  out  DATA_W  registered read data.
REQ-015 reg_req  out  1  register-side request, held until reg_ack.
REQ-016 reg_we  out  1  1 = write request.
REQ-017 reg_idx  out  max(1,clog2(NUM_REGS))  register index.
REQ-018 reg_wdata  out  DATA_W; reg_strb  out  SB; both stable while reg_req=1.
REQ-019 reg_ack  in  1  register block done; reg_rdata  in  DATA_W, valid with reg_ack.
REQ-020 err_cnt  out  8  saturating count of pslverr responses.

Function
REQ-021 FSM states SHALL be IDLE, WAIT_ACK, RESP.
REQ-022 In IDLE, psel=1 && penable=0 (setup) SHALL capture paddr, pwrite, pwdata, pstrb and decode.
REQ-023 Decode error: address not SB-aligned, below BASE_ADDR, index >= NUM_REGS, write to RO register, or read with pstrb != 0.
REQ-024 Decode error: go to RESP with error flag set; no reg_req issued.
REQ-025 Write with pstrb=0 and no decode error: go to RESP, no reg_req, pslverr=0.
REQ-026 Otherwise go to WAIT_ACK: reg_req=1 and reg_we/reg_idx/reg_wdata/reg_strb driven from captured values; timeout counter cleared.
REQ-027 In WAIT_ACK, timeout counter SHALL increment every cycle without reg_ack.
REQ-028 reg_ack=1 in WAIT_ACK: drop reg_req next cycle, capture reg_rdata on reads, go to RESP without error.
REQ-029 Counter reaching TIMEOUT without reg_ack: drop reg_req, go to RESP with error; reg_ack in the same cycle takes priority (no error).
REQ-030 RESP: pready=1 for exactly one cycle; pslverr=error flag; prdata=captured data on successful read, else 0; next state IDLE.
REQ-031 pready, pslverr, prdata SHALL be 0 in every cycle outside RESP.
REQ-032 Latency from setup cycle to pready: 1 cycle on decode error or pstrb=0 write; 2 + (cycles reg_ack is late) otherwise.
REQ-033 psel falls before RESP (protocol abort): complete any open reg_req handshake, suppress pready, return to IDLE; err_cnt unchanged.
REQ-034 reg_ack outside WAIT_ACK SHALL be ignored.
REQ-035 err_cnt SHALL increment by one per RESP cycle with pslverr=1 and saturate at 255.

Reset
REQ-036 preset=1 at a clock edge SHALL force IDLE, clear all outputs and internal registers to 0 (pready, pslverr, prdata, reg_req, reg_we, reg_idx, reg_wdata, reg_strb, err_cnt), including mid-transfer; an in-flight reg_req is dropped.
REQ-037 The first setup phase after preset deasserts SHALL be accepted normally.

Verification
REQ-038 Write 0xA5A5A5A5 to 0x004, pstrb=0xF, reg_ack in the first WAIT_ACK cycle -> reg_req one cycle, reg_idx=1, reg_strb=0xF, pready in cycle 2, pslverr=0.
REQ-039 Read 0x008, reg_ack after 3 extra cycles with reg_rdata=0x12345678 -> prdata=0x12345678 with pready in cycle 5, pslverr=0.
REQ-040 Read 0x014 (index 5) and read 0x002 (misaligned) -> pready in cycle 1, pslverr=1, prdata=0, no reg_req, err_cnt 0->2.
REQ-041 RO_MASK=0b00001, write 0x000 -> pslverr=1; write 0x00C with pstrb=0 -> pslverr=0, no reg_req.
REQ-042 Read 0x00C, reg_ack never asserted, TIMEOUT=15 -> reg_req deasserted after 15 WAIT_ACK cycles, pready with pslverr=1; 256 such errors leave err_cnt=255.
REQ-043 preset=1 during WAIT_ACK -> next cycle reg_req=0, pready=0, err_cnt=0; following read of 0x000 completes normally.
